// File: rtl/irq_sequencer_if.sv
// rtl/irq_sequencer_if.sv - byte-wide memory bus between irq_sequencer and memory
//
// Purpose: groups the memory request/response signals of the interrupt
// entry sequencer into one bundle.
// Signals:
//   req    access request (master -> slave)
//   we     1 = write, 0 = read
//   addr   16-bit access address
//   wdata  8-bit write data
//   rdata  8-bit read data, valid with rdy
//   rdy    access completes on an edge where req and rdy are both high
interface irq_sequencer_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        rdy;

   modport master (output req, we, addr, wdata, input rdata, rdy);
   modport slave  (input req, we, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - BrainForge8 CPU-side interrupt entry sequencer
//
// Purpose: consumes the interrupt controller handshake, stalls the core at an
// instruction boundary, pushes the return context onto the stack, fetches the
// 16-bit handler vector and hands PC/SP back to the core with an ACK.
// Optional feature macro: BF8_IRQ_PUSH_FLAGS_EN (also push the flags byte).
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_next_on/_id      pending interrupt and its id
//   i_reset_on         non-maskable reset-class request
//   i_ie, i_boundary   core interrupt enable, instruction boundary
//   i_pc_in, i_sp_in   return address, current stack pointer
//   i_flags_in         core flags byte
//   bus                memory bus (master side)
//   o_hold             core stall, high outside IDLE
//   o_pc_out/o_pc_load handler address and its load pulse
//   o_sp_out/o_sp_load new stack pointer and its load pulse
//   o_ie_clr           clear core IE pulse
//   o_ack              acknowledge to the interrupt controller
module irq_sequencer #(
   parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_next_on,
   input  logic [3:0]             i_next_id,
   input  logic                   i_reset_on,
   input  logic                   i_ie,
   input  logic                   i_boundary,
   input  logic [15:0]            i_pc_in,
   input  logic [15:0]            i_sp_in,
   input  logic [7:0]             i_flags_in,
   irq_sequencer_if.master        bus,
   output logic                   o_hold,
   output logic [15:0]            o_pc_out,
   output logic                   o_pc_load,
   output logic [15:0]            o_sp_out,
   output logic                   o_sp_load,
   output logic                   o_ie_clr,
   output logic                   o_ack
);

`ifdef BF8_IRQ_PUSH_FLAGS_EN
   localparam logic [15:0] PUSH_CNT = 16'd3;
`else
   localparam logic [15:0] PUSH_CNT = 16'd2;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH_H,
      S_PUSH_L,
`ifdef BF8_IRQ_PUSH_FLAGS_EN
      S_PUSH_F,
`endif
      S_VEC_L,
      S_VEC_H,
      S_DONE
   } state_t;

   state_t      r_state, w_state;
   logic [3:0]  r_id, w_id;
   logic [15:0] r_pc, w_pc;
   logic [15:0] r_sp, w_sp;
   logic        r_is_rst, w_is_rst;
   logic        r_req, w_req;
   logic        r_we, w_we;
   logic [15:0] r_addr, w_addr;
   logic [7:0]  r_wdata, w_wdata;
   logic [15:0] r_pc_out, w_pc_out;
   logic [15:0] r_sp_out, w_sp_out;
   logic        r_hold, w_hold;
   logic        r_pc_load, w_pc_load;
   logic        r_sp_load, w_sp_load;
   logic        r_ie_clr, w_ie_clr;
   logic        r_ack, w_ack;
   logic        w_xfer;
   logic        w_preempt;
`ifdef BF8_IRQ_PUSH_FLAGS_EN
   logic [7:0]  r_flags, w_flags;
`else
   logic        w_unused_flags;
   assign w_unused_flags = ^i_flags_in;
`endif

   function automatic logic [15:0] f_vec(input logic [3:0] id);
      f_vec = VEC_BASE + {11'd0, id, 1'b0};
   endfunction

   assign w_xfer = r_req & bus.rdy;
   // A reset-class request abandons any normal sequence (pushes or vector
   // fetch) but never restarts a reset fetch already in flight. DONE is left
   // to finish; a still-pending request is then taken from IDLE.
   assign w_preempt = i_reset_on & ~r_is_rst & (r_state != S_IDLE) & (r_state != S_DONE);

   always_comb begin
      w_state   = r_state;
      w_id      = r_id;
      w_pc      = r_pc;
      w_sp      = r_sp;
      w_is_rst  = r_is_rst;
      w_req     = r_req;
      w_we      = r_we;
      w_addr    = r_addr;
      w_wdata   = r_wdata;
      w_pc_out  = r_pc_out;
      w_sp_out  = r_sp_out;
      w_hold    = r_hold;
      w_pc_load = 1'b0;
      w_sp_load = 1'b0;
      w_ie_clr  = 1'b0;
      w_ack     = 1'b0;
`ifdef BF8_IRQ_PUSH_FLAGS_EN
      w_flags   = r_flags;
`endif
      if (w_preempt) begin
         // The pending write is dropped and replaced by the vector read.
         w_id     = i_next_id;
         w_is_rst = 1'b1;
         w_state  = S_VEC_L;
         w_req    = 1'b1;
         w_we     = 1'b0;
         w_addr   = f_vec(i_next_id);
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_reset_on) begin
                  w_id     = i_next_id;
                  w_is_rst = 1'b1;
                  w_hold   = 1'b1;
                  w_state  = S_VEC_L;
                  w_req    = 1'b1;
                  w_we     = 1'b0;
                  w_addr   = f_vec(i_next_id);
               end else if (i_next_on & i_ie & i_boundary) begin
                  w_id     = i_next_id;
                  w_pc     = i_pc_in;
                  w_sp     = i_sp_in;
`ifdef BF8_IRQ_PUSH_FLAGS_EN
                  w_flags  = i_flags_in;
`endif
                  w_is_rst = 1'b0;
                  w_sp_out = i_sp_in - PUSH_CNT;
                  w_hold   = 1'b1;
                  w_state  = S_PUSH_H;
                  w_req    = 1'b1;
                  w_we     = 1'b1;
                  w_addr   = i_sp_in;
                  w_wdata  = i_pc_in[15:8];
               end
            end
            S_PUSH_H: if (w_xfer) begin
               w_state = S_PUSH_L;
               w_addr  = r_sp - 16'd1;
               w_wdata = r_pc[7:0];
            end
            S_PUSH_L: if (w_xfer) begin
`ifdef BF8_IRQ_PUSH_FLAGS_EN
               w_state = S_PUSH_F;
               w_addr  = r_sp - 16'd2;
               w_wdata = r_flags;
`else
               w_state = S_VEC_L;
               w_we    = 1'b0;
               w_addr  = f_vec(r_id);
`endif
            end
`ifdef BF8_IRQ_PUSH_FLAGS_EN
            S_PUSH_F: if (w_xfer) begin
               w_state = S_VEC_L;
               w_we    = 1'b0;
               w_addr  = f_vec(r_id);
            end
`endif
            S_VEC_L: if (w_xfer) begin
               w_pc_out[7:0] = bus.rdata;
               w_state       = S_VEC_H;
               w_addr        = f_vec(r_id) + 16'd1;
            end
            S_VEC_H: if (w_xfer) begin
               w_pc_out[15:8] = bus.rdata;
               w_state        = S_DONE;
               w_req          = 1'b0;
               w_pc_load      = 1'b1;
               w_ack          = 1'b1;
               w_sp_load      = ~r_is_rst;
               w_ie_clr       = ~r_is_rst;
            end
            S_DONE: begin
               w_state = S_IDLE;
               w_hold  = 1'b0;
            end
            default: w_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_id      <= 4'd0;
         r_pc      <= 16'd0;
         r_sp      <= 16'd0;
         r_is_rst  <= 1'b0;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= 16'd0;
         r_wdata   <= 8'd0;
         r_pc_out  <= 16'd0;
         r_sp_out  <= 16'd0;
         r_hold    <= 1'b0;
         r_pc_load <= 1'b0;
         r_sp_load <= 1'b0;
         r_ie_clr  <= 1'b0;
         r_ack     <= 1'b0;
`ifdef BF8_IRQ_PUSH_FLAGS_EN
         r_flags   <= 8'd0;
`endif
      end else begin
         r_state   <= w_state;
         r_id      <= w_id;
         r_pc      <= w_pc;
         r_sp      <= w_sp;
         r_is_rst  <= w_is_rst;
         r_req     <= w_req;
         r_we      <= w_we;
         r_addr    <= w_addr;
         r_wdata   <= w_wdata;
         r_pc_out  <= w_pc_out;
         r_sp_out  <= w_sp_out;
         r_hold    <= w_hold;
         r_pc_load <= w_pc_load;
         r_sp_load <= w_sp_load;
         r_ie_clr  <= w_ie_clr;
         r_ack     <= w_ack;
`ifdef BF8_IRQ_PUSH_FLAGS_EN
         r_flags   <= w_flags;
`endif
      end
   end

   assign bus.req   = r_req;
   assign bus.we    = r_we;
   assign bus.addr  = r_addr;
   assign bus.wdata = r_wdata;
   assign o_hold    = r_hold;
   assign o_pc_out  = r_pc_out;
   assign o_pc_load = r_pc_load;
   assign o_sp_out  = r_sp_out;
   assign o_sp_load = r_sp_load;
   assign o_ie_clr  = r_ie_clr;
   assign o_ack     = r_ack;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - self-checking bench for irq_sequencer
module tb_irq_sequencer;

   localparam logic [15:0] VEC_BASE = 16'hFFE0;
`ifdef BF8_IRQ_PUSH_FLAGS_EN
   localparam int NPUSH = 3;
`else
   localparam int NPUSH = 2;
`endif

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  data;
   } txn_t;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_next_on;
   logic [3:0]  i_next_id;
   logic        i_reset_on;
   logic        i_ie;
   logic        i_boundary;
   logic [15:0] i_pc_in;
   logic [15:0] i_sp_in;
   logic [7:0]  i_flags_in;
   logic        o_hold;
   logic [15:0] o_pc_out;
   logic        o_pc_load;
   logic [15:0] o_sp_out;
   logic        o_sp_load;
   logic        o_ie_clr;
   logic        o_ack;

   irq_sequencer_if bus();

   irq_sequencer #(.VEC_BASE(VEC_BASE)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_next_on  (i_next_on),
      .i_next_id  (i_next_id),
      .i_reset_on (i_reset_on),
      .i_ie       (i_ie),
      .i_boundary (i_boundary),
      .i_pc_in    (i_pc_in),
      .i_sp_in    (i_sp_in),
      .i_flags_in (i_flags_in),
      .bus        (bus),
      .o_hold     (o_hold),
      .o_pc_out   (o_pc_out),
      .o_pc_load  (o_pc_load),
      .o_sp_out   (o_sp_out),
      .o_sp_load  (o_sp_load),
      .o_ie_clr   (o_ie_clr),
      .o_ack      (o_ack)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          waits_used, stab_err, wait_left;
   bit          pend, allow_abort, rand_waits;
   logic [15:0] p_addr;
   logic        p_we;
   logic [7:0]  p_wdata;
   int          wait_plan[$];
   txn_t        txns[$];
   logic [7:0]  vt[32];

   // Memory model: vector table window at VEC_BASE, a fixed pattern elsewhere.
   function automatic logic [7:0] rd_byte(input logic [15:0] a);
      logic [15:0] off;
      off = a - VEC_BASE;
      if (a >= VEC_BASE) return vt[off[4:0]];
      return 8'h5A ^ a[7:0];
   endfunction

   // One clock cycle: bus slave response plus a record of every completed access.
   task automatic step();
      bit   new_txn;
      txn_t t;
      @(negedge clk);
      cyc++;
      if (bus.req === 1'b1) begin
         new_txn = !pend;
         if (pend && (bus.addr !== p_addr || bus.we !== p_we || (bus.we && bus.wdata !== p_wdata))) begin
            if (allow_abort) new_txn = 1'b1;
            else stab_err++;
         end
         if (new_txn) wait_left = (wait_plan.size() > 0) ? wait_plan.pop_front()
                                  : (rand_waits ? int'($urandom_range(0, 2)) : 0);
         p_addr = bus.addr; p_we = bus.we; p_wdata = bus.wdata;
         if (wait_left > 0) begin
            bus.rdy = 1'b0; wait_left--; waits_used++; pend = 1'b1;
         end else begin
            bus.rdy = 1'b1; bus.rdata = rd_byte(bus.addr); pend = 1'b0;
            t.we = bus.we; t.addr = bus.addr; t.data = bus.we ? bus.wdata : bus.rdata;
            txns.push_back(t);
         end
      end else begin
         bus.rdy = 1'($urandom); bus.rdata = 8'($urandom); pend = 1'b0;
      end
   endtask

   // Drives one interrupt entry and checks it against the transaction-level model.
   task automatic run_entry(input string nm, input bit rst_e, input logic [3:0] id,
                            input logic [15:0] pc, input logic [15:0] sp, input logic [7:0] fl,
                            input int pre_gate, input int pre_off, input logic [3:0] pre_id);
      txn_t        exp_q[$];
      txn_t        t;
      int          acc, done_c, n_ack, n_pcl, n_spl, n_iec, hold_bad, exp_done, n_push;
      bit          got, exp_norm;
      logic [3:0]  eid;
      logic [15:0] va, pc_obs, sp_obs, exp_pc;
      for (int i = 0; i < pre_gate; i++) begin
         i_next_on = 1'b1; i_ie = i[0]; i_boundary = ~i[0]; i_reset_on = 1'b0;
         i_next_id = 4'($urandom);
         step();
         total++;
         if (o_hold !== 1'b0 || bus.req !== 1'b0) begin
            bad++; $display("FAIL %s gate hold=%b req=%b exp=0", nm, o_hold, bus.req);
         end
      end
      txns.delete(); waits_used = 0; stab_err = 0; allow_abort = (pre_off != 0);
      i_next_id = id; i_pc_in = pc; i_sp_in = sp; i_flags_in = fl;
      if (rst_e) begin
         i_reset_on = 1'b1; i_ie = 1'b0; i_next_on = 1'($urandom); i_boundary = 1'($urandom);
      end else begin
         i_reset_on = 1'b0; i_ie = 1'b1; i_next_on = 1'b1; i_boundary = 1'b1;
      end
      acc = cyc; got = 0; done_c = -1; n_ack = 0; n_pcl = 0; n_spl = 0; n_iec = 0; hold_bad = 0;
      pc_obs = 16'hx; sp_obs = 16'hx;
      for (int k = 1; k <= 60 && !got; k++) begin
         step();
         if (k == 1) begin
            i_next_on = 1'b0; i_reset_on = 1'b0; i_next_id = 4'($urandom);
            i_ie = 1'($urandom); i_boundary = 1'($urandom);
            i_pc_in = 16'($urandom); i_sp_in = 16'($urandom); i_flags_in = 8'($urandom);
         end
         if (pre_off != 0 && k == pre_off) begin i_reset_on = 1'b1; i_next_id = pre_id; end
         if (pre_off != 0 && k == pre_off + 1) i_reset_on = 1'b0;
         if (o_hold !== 1'b1) hold_bad++;
         if (o_pc_load === 1'b1) n_pcl++;
         if (o_sp_load === 1'b1) n_spl++;
         if (o_ie_clr === 1'b1) n_iec++;
         if (o_ack === 1'b1) begin
            n_ack++; got = 1; done_c = cyc - acc; pc_obs = o_pc_out; sp_obs = o_sp_out;
         end
      end
      step();
      total++;
      if (o_hold !== 1'b0 || o_ack !== 1'b0 || o_pc_load !== 1'b0 || o_sp_load !== 1'b0 || o_ie_clr !== 1'b0) begin
         bad++;
         $display("FAIL %s after_done hold=%b ack=%b pcl=%b spl=%b iec=%b exp=0", nm,
                  o_hold, o_ack, o_pc_load, o_sp_load, o_ie_clr);
      end

      exp_norm = !rst_e && (pre_off == 0);
      n_push   = rst_e ? 0 : ((pre_off != 0) ? pre_off - 1 : NPUSH);
      eid      = (pre_off != 0) ? pre_id : id;
      va       = VEC_BASE + 16'(2 * int'(eid));
      exp_pc   = {vt[{eid, 1'b1}], vt[{eid, 1'b0}]};
      exp_done = (pre_off != 0) ? pre_off + 3 : ((rst_e ? 0 : NPUSH) + 3 + waits_used);
      for (int i = 0; i < n_push; i++) begin
         t.we = 1'b1; t.addr = sp - 16'(i);
         t.data = (i == 0) ? pc[15:8] : ((i == 1) ? pc[7:0] : fl);
         exp_q.push_back(t);
      end
      t.we = 1'b0; t.addr = va;         t.data = vt[{eid, 1'b0}]; exp_q.push_back(t);
      t.we = 1'b0; t.addr = va + 16'd1; t.data = vt[{eid, 1'b1}]; exp_q.push_back(t);

      total++;
      if (done_c != exp_done) begin bad++; $display("FAIL %s done_cycle got=%0d exp=%0d", nm, done_c, exp_done); end
      total++;
      if (n_ack != 1) begin bad++; $display("FAIL %s ack_pulses got=%0d exp=1", nm, n_ack); end
      total++;
      if (n_pcl != 1) begin bad++; $display("FAIL %s pc_load_pulses got=%0d exp=1", nm, n_pcl); end
      total++;
      if (n_spl != int'(exp_norm)) begin bad++; $display("FAIL %s sp_load_pulses got=%0d exp=%0d", nm, n_spl, exp_norm); end
      total++;
      if (n_iec != int'(exp_norm)) begin bad++; $display("FAIL %s ie_clr_pulses got=%0d exp=%0d", nm, n_iec, exp_norm); end
      total++;
      if (pc_obs !== exp_pc) begin bad++; $display("FAIL %s pc_out got=%h exp=%h", nm, pc_obs, exp_pc); end
      if (exp_norm) begin
         total++;
         if (sp_obs !== sp - 16'(NPUSH)) begin bad++; $display("FAIL %s sp_out got=%h exp=%h", nm, sp_obs, sp - 16'(NPUSH)); end
      end
      total++;
      if (hold_bad != 0) begin bad++; $display("FAIL %s hold_low_cycles got=%0d exp=0", nm, hold_bad); end
      total++;
      if (stab_err != 0) begin bad++; $display("FAIL %s bus_unstable_cycles got=%0d exp=0", nm, stab_err); end
      total++;
      if (txns.size() != exp_q.size()) begin
         bad++; $display("FAIL %s bus_txn_count got=%0d exp=%0d", nm, txns.size(), exp_q.size());
      end
      for (int i = 0; i < txns.size() && i < exp_q.size(); i++) begin
         total++;
         if (txns[i].we !== exp_q[i].we || txns[i].addr !== exp_q[i].addr ||
             (exp_q[i].we && txns[i].data !== exp_q[i].data)) begin
            bad++;
            $display("FAIL %s bus_txn%0d got=we%b %h:%h exp=we%b %h:%h", nm, i, txns[i].we, txns[i].addr,
                     txns[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_reset_on = 1'b1; i_next_on = 1'b1; i_ie = 1'b1; i_boundary = 1'b1; i_next_id = 4'hF;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if ({o_hold, o_ack, o_pc_load, o_sp_load, o_ie_clr, bus.req, bus.we} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0000000", {o_hold, o_ack, o_pc_load, o_sp_load, o_ie_clr, bus.req, bus.we});
         end
         total++;
         if (o_pc_out !== 16'h0 || o_sp_out !== 16'h0 || bus.addr !== 16'h0 || bus.wdata !== 8'h0) begin
            bad++;
            $display("FAIL reset_data got=pc%h sp%h a%h d%h exp=0", o_pc_out, o_sp_out, bus.addr, bus.wdata);
         end
      end
      i_reset_on = 1'b0; i_next_on = 1'b0; i_rst = 1'b0;
      step();
      total++;
      if (o_hold !== 1'b0) begin bad++; $display("FAIL reset_release hold=%b exp=0", o_hold); end
   endtask

   task automatic test_normal();
      rand_waits = 0; wait_plan.delete();
      run_entry("normal", 1'b0, 4'd4, 16'h1234, 16'h01FF, 8'hA5, 0, 0, 4'd0);
   endtask

   task automatic test_gating();
      rand_waits = 0; wait_plan.delete();
      run_entry("gating", 1'b0, 4'd9, 16'hBEEF, 16'h8000, 8'h3C, 4, 0, 4'd0);
   endtask

   task automatic test_reset_entry();
      rand_waits = 0; wait_plan.delete();
      run_entry("reset_entry", 1'b1, 4'd0, 16'h4321, 16'h0100, 8'h11, 0, 0, 4'd0);
   endtask

   task automatic test_wait_states();
      rand_waits = 0; wait_plan.delete();
      wait_plan.push_back(0); wait_plan.push_back(2);
      run_entry("wait_states", 1'b0, 4'd4, 16'h1234, 16'h01FF, 8'hA5, 0, 0, 4'd0);
   endtask

   // RESET_ON arrives while the PUSH_L write is being held off by the bus.
   task automatic test_reset_mid();
      rand_waits = 0; wait_plan.delete();
      wait_plan.push_back(0); wait_plan.push_back(5);
      run_entry("reset_mid", 1'b0, 4'd2, 16'hCAFE, 16'h0200, 8'h77, 0, 2, 4'd7);
      wait_plan.delete();
   endtask

   task automatic test_back_to_back();
      bit          r;
      logic [15:0] sp;
      rand_waits = 1; wait_plan.delete();
      for (int n = 0; n < 16; n++) begin
         r  = ($urandom_range(0, 3) == 0);
         sp = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
         run_entry($sformatf("b2b%0d", n), r, 4'($urandom), 16'($urandom), sp, 8'($urandom),
                   int'($urandom_range(0, 2)), 0, 4'd0);
      end
      rand_waits = 0;
   endtask

   initial begin
      i_rst = 1'b1; i_next_on = 1'b0; i_next_id = 4'd0; i_reset_on = 1'b0; i_ie = 1'b0;
      i_boundary = 1'b0; i_pc_in = 16'd0; i_sp_in = 16'd0; i_flags_in = 8'd0;
      bus.rdy = 1'b0; bus.rdata = 8'd0;
      pend = 1'b0; allow_abort = 1'b0; rand_waits = 1'b0; wait_left = 0;
      waits_used = 0; stab_err = 0;
      for (int i = 0; i < 32; i++) vt[i] = 8'($urandom);
      vt[8] = 8'h78; vt[9] = 8'h56;
      test_reset();
      test_normal();
      test_gating();
      test_reset_entry();
      test_wait_states();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
